// File: rtl/alu_arbiter_pkg.sv
// Shared constants and types for the two-requester ALU arbiter.
// ALUFun encodings match the existing shared ALU.
package alu_arbiter_pkg;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned FUN_W   = 6;
  localparam int unsigned SHAMT_W = $clog2(DATA_W);

  localparam logic [FUN_W-1:0] FUN_ADD = 6'b000000;
  localparam logic [FUN_W-1:0] FUN_SUB = 6'b000001;
  localparam logic [FUN_W-1:0] FUN_AND = 6'b011000;
  localparam logic [FUN_W-1:0] FUN_OR  = 6'b011110;
  localparam logic [FUN_W-1:0] FUN_XOR = 6'b010110;
  localparam logic [FUN_W-1:0] FUN_NOR = 6'b010001;
  localparam logic [FUN_W-1:0] FUN_SLL = 6'b100000;
  localparam logic [FUN_W-1:0] FUN_SRL = 6'b100001;
  localparam logic [FUN_W-1:0] FUN_SRA = 6'b100011;
  localparam logic [FUN_W-1:0] FUN_EQ  = 6'b110011;
  localparam logic [FUN_W-1:0] FUN_NE  = 6'b110001;
  localparam logic [FUN_W-1:0] FUN_LT  = 6'b110101;

  typedef struct packed {
    logic [FUN_W-1:0]  fun;
    logic              sign;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } alu_op_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Shared combinational ALU: S = f(fun, sign, A, B); shifts move B by A[4:0].
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [FUN_W-1:0]  fun_i,
  input  logic              sign_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] s_o
);

  logic [SHAMT_W-1:0] shamt;
  logic               lt;

  assign shamt = a_i[SHAMT_W-1:0];
  assign lt    = sign_i ? ($signed(a_i) < $signed(b_i)) : (a_i < b_i);

  always_comb begin
    s_o = '0;
    case (fun_i)
      FUN_ADD: s_o = a_i + b_i;
      FUN_SUB: s_o = a_i - b_i;
      FUN_AND: s_o = a_i & b_i;
      FUN_OR:  s_o = a_i | b_i;
      FUN_XOR: s_o = a_i ^ b_i;
      FUN_NOR: s_o = ~(a_i | b_i);
      FUN_SLL: s_o = b_i << shamt;
      FUN_SRL: s_o = b_i >> shamt;
      FUN_SRA: s_o = DATA_W'($signed(b_i) >>> shamt);
      FUN_EQ:  s_o = DATA_W'(a_i == b_i);
      FUN_NE:  s_o = DATA_W'(a_i != b_i);
      FUN_LT:  s_o = DATA_W'(lt);
      default: s_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end to a single shared ALU: arbitrate, issue one op per
// cycle, hold each requester's result until it is consumed.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned RR_EN = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [FUN_W-1:0]  req0_fun,
  input  logic              req0_sign,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [FUN_W-1:0]  req1_fun,
  input  logic              req1_sign,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_data,
  output logic [CNT_W-1:0]  ops_done
);

  logic [NUM_REQ-1:0] req_valid, eligible, grant_c, accept, pop, rsp_ready;
  alu_op_t            req_op [NUM_REQ];

  logic [NUM_REQ-1:0] pend_q, pend_d;
  logic               last_q, last_d;
  logic               iss_valid_q, iss_valid_d;
  logic               iss_id_q, iss_id_d;
  alu_op_t            iss_op_q, iss_op_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_data_q [NUM_REQ];
  logic [DATA_W-1:0]  rsp_data_d [NUM_REQ];
  logic [CNT_W-1:0]   ops_done_q, ops_done_d;
  logic [DATA_W-1:0]  alu_s;

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};
  assign req_op[0] = {req0_fun, req0_sign, req0_a, req0_b};
  assign req_op[1] = {req1_fun, req1_sign, req1_a, req1_b};

  // pend_q blocks re-accept until the held result is popped
  assign eligible = req_valid & ~pend_q;
  assign accept   = req_valid & grant_c;
  assign pop      = rsp_valid_q & rsp_ready;

  // At most one grant; on contention RR picks the index that did not win last
  always_comb begin
    grant_c = '0;
    if (reset) begin
      if (&eligible) begin
        if ((RR_EN != 0) && !last_q) grant_c = 2'b10;
        else                         grant_c = 2'b01;
      end else begin
        grant_c = eligible;
      end
    end
  end

  assign req0_ready = grant_c[0];
  assign req1_ready = grant_c[1];

  alu_arbiter_alu u_alu (
    .fun_i  (iss_op_q.fun),
    .sign_i (iss_op_q.sign),
    .a_i    (iss_op_q.a),
    .b_i    (iss_op_q.b),
    .s_o    (alu_s)
  );

  always_comb begin
    pend_d      = (pend_q & ~pop) | accept;
    last_d      = last_q;
    iss_valid_d = |accept;
    iss_id_d    = iss_id_q;
    iss_op_d    = iss_op_q;
    rsp_valid_d = rsp_valid_q & ~pop;
    rsp_data_d  = rsp_data_q;
    ops_done_d  = ops_done_q + CNT_W'(pop[0]) + CNT_W'(pop[1]);

    if (|accept) begin
      last_d   = accept[1];
      iss_id_d = accept[1];
      iss_op_d = req_op[accept[1]];
    end

    if (iss_valid_q) begin
      rsp_valid_d[iss_id_q] = 1'b1;
      rsp_data_d[iss_id_q]  = alu_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_q        <= '0;
      last_q        <= 1'b1;
      iss_valid_q   <= 1'b0;
      iss_id_q      <= 1'b0;
      iss_op_q      <= '0;
      rsp_valid_q   <= '0;
      rsp_data_q[0] <= '0;
      rsp_data_q[1] <= '0;
      ops_done_q    <= '0;
    end else begin
      pend_q        <= pend_d;
      last_q        <= last_d;
      iss_valid_q   <= iss_valid_d;
      iss_id_q      <= iss_id_d;
      iss_op_q      <= iss_op_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q[0] <= rsp_data_d[0];
      rsp_data_q[1] <= rsp_data_d[1];
      ops_done_q    <= ops_done_d;
    end
  end

  assign rsp0_valid = rsp_valid_q[0];
  assign rsp1_valid = rsp_valid_q[1];
  assign rsp0_data  = rsp_data_q[0];
  assign rsp1_data  = rsp_data_q[1];
  assign ops_done   = ops_done_q;

endmodule
